// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I load/store funct3 codes and responder FSM encoding
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      DMR_IDLE = 2'd0,
      DMR_WAIT = 2'd1,
      DMR_RESP = 2'd2
   } dmr_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane steering/byte-enables and load extraction/extension
module dmem_lane_align (
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        we_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);
   import riscv_pkg::*;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
   assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

   always_comb begin
      be_o    = 4'b0000;
      wdata_o = wdata_i;
      rdata_o = '0;
      err_o   = 1'b0;
      case (funct3_i)
         F3_B: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{byte_sel[7]}}, byte_sel};
         end
         F3_H: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{half_sel[15]}}, half_sel};
            err_o   = addr_lo_i[0];
         end
         F3_W: begin
            be_o    = 4'b1111;
            rdata_o = rword_i;
            err_o   = |addr_lo_i;
         end
         // Unsigned variants exist only for loads
         F3_BU: begin
            rdata_o = {24'h0, byte_sel};
            err_o   = we_i;
         end
         F3_HU: begin
            rdata_o = {16'h0, half_sel};
            err_o   = we_i | addr_lo_i[0];
         end
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with valid/ready request and response
module dmem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);
   import riscv_pkg::*;

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   dmr_state_e         state_q;
   logic [3:0]         cnt_q;
   logic               we_q;
   logic [2:0]         funct3_q;
   logic [ADDR_W+1:0]  addr_q;
   logic [31:0]        wdata_q;
   logic [31:0]        mem_q [DEPTH];

   logic               req_fire;
   logic               enter_resp;
   logic               acc_we;
   logic [2:0]         acc_funct3;
   logic [ADDR_W+1:0]  acc_addr;
   logic [31:0]        acc_wdata;
   logic [3:0]         be;
   logic [31:0]        lane_wdata;
   logic [31:0]        ld_data;
   logic               acc_err;
   logic [31:0]        rsp_rdata_d;
   logic               rsp_err_d;
   logic               unused_addr_hi;

   assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];
   assign req_fire       = req_valid_i & req_ready_o;
   assign enter_resp     = ((state_q == DMR_IDLE) && req_fire && (LATENCY == 1)) ||
                           ((state_q == DMR_WAIT) && (cnt_q == 4'd1));

   // With LATENCY==1 the access happens on the accept edge, before the latch holds it
   always_comb begin
      if (state_q == DMR_IDLE) begin
         acc_we     = req_we_i;
         acc_funct3 = req_funct3_i;
         acc_addr   = req_addr_i[ADDR_W+1:0];
         acc_wdata  = req_wdata_i;
      end else begin
         acc_we     = we_q;
         acc_funct3 = funct3_q;
         acc_addr   = addr_q;
         acc_wdata  = wdata_q;
      end
   end

   dmem_lane_align u_align (
      .funct3_i  (acc_funct3),
      .addr_lo_i (acc_addr[1:0]),
      .we_i      (acc_we),
      .wdata_i   (acc_wdata),
      .rword_i   (mem_q[acc_addr[ADDR_W+1:2]]),
      .be_o      (be),
      .wdata_o   (lane_wdata),
      .rdata_o   (ld_data),
      .err_o     (acc_err)
   );

   assign rsp_rdata_d = (acc_we | acc_err) ? 32'h0 : ld_data;
   assign rsp_err_d   = acc_err;

   always_ff @(posedge clk) begin
      if (enter_resp && acc_we && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[acc_addr[ADDR_W+1:2]][8*b +: 8] <= lane_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DMR_IDLE;
         cnt_q       <= 4'd0;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= 32'h0;
         rsp_err_o   <= 1'b0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
      end else begin
         unique case (state_q)
            DMR_IDLE: begin
               if (req_fire) begin
                  we_q        <= req_we_i;
                  funct3_q    <= req_funct3_i;
                  addr_q      <= req_addr_i[ADDR_W+1:0];
                  wdata_q     <= req_wdata_i;
                  req_ready_o <= 1'b0;
                  state_q     <= DMR_WAIT;
                  cnt_q       <= CNT_INIT;
               end
            end
            DMR_WAIT: cnt_q <= cnt_q - 4'd1;
            DMR_RESP: begin
               if (rsp_ready_i) begin
                  state_q     <= DMR_IDLE;
                  req_ready_o <= 1'b1;
                  rsp_valid_o <= 1'b0;
                  rsp_rdata_o <= 32'h0;
                  rsp_err_o   <= 1'b0;
               end
            end
            default: state_q <= DMR_IDLE;
         endcase
         if (enter_resp) begin
            state_q     <= DMR_RESP;
            cnt_q       <= 4'd0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LATENCY 2 and 1
module tb_dmem_responder;
   import riscv_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        sel   = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_ready = 1'b0;

   logic        rdy2, vld2, err2, rdy1, vld1, err1;
   logic [31:0] rd2, rd1;
   logic        dut_ready, dut_valid, dut_err;
   logic [31:0] dut_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid & ~sel), .req_ready_o(rdy2),
      .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(vld2), .rsp_ready_i(rsp_ready & ~sel), .rsp_rdata_o(rd2), .rsp_err_o(err2)
   );

   dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid & sel), .req_ready_o(rdy1),
      .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(vld1), .rsp_ready_i(rsp_ready & sel), .rsp_rdata_o(rd1), .rsp_err_o(err1)
   );

   assign dut_ready = sel ? rdy1 : rdy2;
   assign dut_valid = sel ? vld1 : vld2;
   assign dut_rdata = sel ? rd1  : rd2;
   assign dut_err   = sel ? err1 : err2;

   // Reference model: byte-addressed little-endian memory, one outstanding access
   logic [7:0]  mbytes [4096];
   logic        m_busy = 1'b0;
   int          m_age  = 0;
   int          m_lat;
   logic [31:0] exp_rdata = 32'h0;
   logic        exp_err   = 1'b0;
   logic        p_we;
   logic [2:0]  p_f3;
   logic [31:0] p_addr, p_wdata;
   logic        c_fire, c_we;
   logic [2:0]  c_f3;
   logic [31:0] c_addr, c_wdata;

   assign m_lat = sel ? 1 : 2;

   function automatic int acc_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic acc_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
      logic bad_f3;
      bad_f3 = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      return bad_f3 || ((a % 32'(acc_size(f3))) != 32'h0);
   endfunction

   function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a);
      int n;
      logic [31:0] v;
      n = acc_size(f3);
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mbytes[int'((a + 32'(i)) & 32'hFFF)]) << (8 * i));
      if (!f3[2] && n < 4) v = 32'($signed(v << (32 - 8 * n)) >>> (32 - 8 * n));
      return v;
   endfunction

   always_comb begin
      c_fire  = 1'b0;
      c_we    = p_we;
      c_f3    = p_f3;
      c_addr  = p_addr;
      c_wdata = p_wdata;
      if (m_busy) begin
         c_fire = (m_age < m_lat) && (m_age + 1 == m_lat);
      end else begin
         c_fire  = req_valid && (m_lat == 1);
         c_we    = req_we;
         c_f3    = req_funct3;
         c_addr  = req_addr;
         c_wdata = req_wdata;
      end
   end

   always @(posedge clk) begin
      if (rst_n && c_fire && c_we && !acc_illegal(c_we, c_f3, c_addr)) begin
         for (int i = 0; i < 4; i++)
            if (i < acc_size(c_f3)) mbytes[int'((c_addr + 32'(i)) & 32'hFFF)] <= c_wdata[8*i +: 8];
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_age  <= 0;
      end else if (m_busy) begin
         if (m_age >= m_lat) begin
            if (rsp_ready) m_busy <= 1'b0;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (req_valid) begin
         p_we      <= req_we;
         p_f3      <= req_funct3;
         p_addr    <= req_addr;
         p_wdata   <= req_wdata;
         exp_err   <= acc_illegal(req_we, req_funct3, req_addr);
         exp_rdata <= (req_we || acc_illegal(req_we, req_funct3, req_addr)) ? 32'h0
                                                                             : load_value(req_funct3, req_addr);
         m_busy    <= 1'b1;
         m_age     <= 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         chk("cyc_req_ready", 32'(dut_ready), 32'(!m_busy));
         chk("cyc_rsp_valid", 32'(dut_valid), 32'(m_busy && (m_age >= m_lat)));
         if (!rst_n) begin
            chk("cyc_reset_rdata", dut_rdata, 32'h0);
            chk("cyc_reset_err", 32'(dut_err), 32'h0);
         end else if (m_busy && (m_age >= m_lat)) begin
            chk("cyc_rsp_rdata", dut_rdata, exp_rdata);
            chk("cyc_rsp_err", 32'(dut_err), 32'(exp_err));
         end
      end
   endtask

   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input int hold, output logic [31:0] rd, output logic e, output int lat);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 1;
      while (!dut_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!dut_valid) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: got no rsp_valid expected one within 40 cycles");
      end
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      rd = dut_rdata;
      e  = dut_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic access(input string name, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_e, input int exp_lat);
      logic [31:0] rd;
      logic e;
      int lat;
      txn(we, f3, a, wd, 0, rd, e, lat);
      chk({name, "_rdata"}, rd, exp_rd);
      chk({name, "_err"}, 32'(e), 32'(exp_e));
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      logic [31:0] rd;
      logic e;
      int lat;
      fork
         monitor();
      join_none
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(dut_ready), 32'h1);
      chk("rst_rsp_valid", 32'(dut_valid), 32'h0);
      chk("rst_rdata", dut_rdata, 32'h0);
      chk("rst_err", 32'(dut_err), 32'h0);
      chk("rst_l1_req_ready", 32'(rdy1), 32'h1);
      rst_n = 1'b1;

      access("t1_sw", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
      access("t1_lw", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

      access("t2_lb",  1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
      access("t2_lbu", 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2);
      access("t2_lh",  1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2);
      access("t2_lhu", 1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2);

      access("t3_sb",  1'b1, F3_B, 32'h11, 32'h00000055, 32'h0, 1'b0, 2);
      access("t3_lw1", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 2);
      access("t3_sh",  1'b1, F3_H, 32'h12, 32'h00001234, 32'h0, 1'b0, 2);
      access("t3_lw2", 1'b0, F3_W, 32'h10, 32'h0, 32'h123455EF, 1'b0, 2);
      access("t3_alias_lw", 1'b0, F3_W, 32'hFFFF_F010, 32'h0, 32'h123455EF, 1'b0, 2);

      access("t4_lw_mis",  1'b0, F3_W,   32'h12, 32'h0, 32'h0, 1'b1, 2);
      access("t4_sh_mis",  1'b1, F3_H,   32'h11, 32'h0000AAAA, 32'h0, 1'b1, 2);
      access("t4_ld_f3_3", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 2);
      access("t4_st_f3_4", 1'b1, F3_BU,  32'h10, 32'h000000FF, 32'h0, 1'b1, 2);
      access("t4_lw_keep", 1'b0, F3_W,   32'h10, 32'h0, 32'h123455EF, 1'b0, 2);

      txn(1'b0, F3_W, 32'h10, 32'h0, 5, rd, e, lat);
      chk("t5_hold_rdata", rd, 32'h123455EF);
      chk("t5_hold_lat", 32'(lat), 32'h2);
      chk("t5_ready_after", 32'(dut_ready), 32'h1);

      access("t6_pre_sw", 1'b1, F3_W, 32'h20, 32'h11112222, 32'h0, 1'b0, 2);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = F3_W;
      req_addr   = 32'h20;
      req_wdata  = 32'hCAFEF00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_rst_ready", 32'(dut_ready), 32'h1);
      chk("t6_rst_valid", 32'(dut_valid), 32'h0);
      chk("t6_rst_rdata", dut_rdata, 32'h0);
      chk("t6_rst_err", 32'(dut_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      txn(1'b0, F3_W, 32'h20, 32'h0, 0, rd, e, lat);
      chk("t6_lw_old", rd, 32'h11112222);
      chk("t6_lw_not_new", 32'(rd == 32'hCAFEF00D), 32'h0);

      @(negedge clk);
      sel = 1'b1;
      access("t7_l1_sw", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
      access("t7_l1_lw", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
      access("t7_l1_lh_mis", 1'b0, F3_H, 32'h11, 32'h0, 32'h0, 1'b1, 1);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
